// File: rtl/reg_write_arbiter_pkg.sv
// Shared defaults and width derivations for the register-bank write arbiter.
// Build option: REGWR_ZERO_REG_EN makes register 0 hardwired zero.
package regwr_pkg;

    // Mirrors the codebase-wide data width constant.
    localparam int DEF_BIT_WIDTH = 8;
    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_NUM_REGS  = 8;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_AW = idx_width(DEF_NUM_REGS);
    localparam int DEF_GW = idx_width(DEF_NUM_REQ);

endpackage

// File: rtl/reg_write_arbiter_rr.sv
// Combinational round-robin search: first valid requester at or above ptr, wrapping.
module rr_arbiter
    import regwr_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int GW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [GW-1:0]      ptr,
    output logic [GW-1:0]      winner,
    output logic               found
);

    int idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && valid[idx]) begin
                found  = 1'b1;
                winner = GW'(idx);
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the register bank's single write port; registered enables/data.
// Build option: REGWR_ZERO_REG_EN keeps reg_en[0] low (register 0 reads as zero).
module reg_write_arbiter
    import regwr_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int AW        = idx_width(NUM_REGS),
    parameter int GW        = idx_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          hold,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*AW-1:0]         req_addr,
    input  logic [NUM_REQ*BIT_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REGS-1:0]           reg_en,
    output logic [BIT_WIDTH-1:0]          reg_d,
    output logic [GW-1:0]                 last_grant
);

    logic [GW-1:0]        ptr;
    logic [GW-1:0]        winner;
    logic                 found;
    logic                 accept;
    logic [AW-1:0]        win_addr;
    logic [BIT_WIDTH-1:0] win_data;
    logic [NUM_REGS-1:0]  en_dec;
    logic [GW-1:0]        ptr_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_rr (
        .valid  (req_valid),
        .ptr    (ptr),
        .winner (winner),
        .found  (found)
    );

    // The search only returns a valid requester, so ready at the winner implies accept.
    assign accept    = found && !hold;
    assign req_ready = accept ? (NUM_REQ'(1) << winner) : '0;
    assign win_addr  = req_addr[winner*AW +: AW];
    assign win_data  = req_data[winner*BIT_WIDTH +: BIT_WIDTH];
    assign ptr_next  = (winner == GW'(NUM_REQ-1)) ? '0 : winner + GW'(1);

    always_comb begin
        en_dec = NUM_REGS'(1) << win_addr;
`ifdef REGWR_ZERO_REG_EN
        en_dec[0] = 1'b0;
`else
        en_dec = en_dec;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_en     <= '0;
            reg_d      <= '0;
            last_grant <= '0;
            ptr        <= '0;
        end else if (accept) begin
            reg_en     <= en_dec;
            reg_d      <= win_data;
            last_grant <= winner;
            ptr        <= ptr_next;
        end else begin
            reg_en     <= '0;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: scoreboard of expected {reg_en, reg_d, last_grant}.
module tb_reg_write_arbiter;

    localparam int BW   = 8;
    localparam int NR   = 4;
    localparam int NG   = 8;
    localparam int AW   = 3;
    localparam int GW   = 2;
    localparam int EW   = NG + BW + GW;

    logic               clk;
    logic               rst;
    logic               hold;
    logic [NR-1:0]      req_valid;
    logic [NR*AW-1:0]   req_addr;
    logic [NR*BW-1:0]   req_data;
    logic [NR-1:0]      req_ready;
    logic [NG-1:0]      reg_en;
    logic [BW-1:0]      reg_d;
    logic [GW-1:0]      last_grant;

    logic [EW-1:0] exp_q[$];
    logic [BW-1:0] bank [NG];
    int n_cmp;
    int n_err;
    int m_ptr;
    int m_last;
    logic [BW-1:0] m_d;

    reg_write_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .hold       (hold),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .reg_en     (reg_en),
        .reg_d      (reg_d),
        .last_grant (last_grant)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural bank register file fed by the arbiter's outputs.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NG; i++) bank[i] <= '0;
        end else begin
            for (int i = 0; i < NG; i++) if (reg_en[i]) bank[i] <= reg_d;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [BW-1:0] d);
        req_valid[i]          = 1'b1;
        req_addr[i*AW +: AW]  = a;
        req_data[i*BW +: BW]  = d;
    endtask

    task automatic clear_req();
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_last = 0;
        m_d    = '0;
        exp_q.delete();
    endtask

    // One clock of stimulus: predict, check ready, push expectation, then pop after the edge.
    task automatic step();
        int w;
        bit fnd;
        logic [NR-1:0] e_ready;
        logic [NG-1:0] e_en;
        logic [AW-1:0] a;
        logic [EW-1:0] got;
        logic [EW-1:0] e;
        #1;
        fnd = 1'b0;
        w   = 0;
        for (int k = 0; k < NR; k++) begin
            if (!fnd && req_valid[(m_ptr + k) % NR]) begin
                fnd = 1'b1;
                w   = (m_ptr + k) % NR;
            end
        end
        e_ready = (fnd && !hold) ? (NR'(1) << w) : '0;
        check("req_ready", 32'(req_ready), 32'(e_ready));
        e_en = '0;
        if (fnd && !hold) begin
            a    = req_addr[w*AW +: AW];
            e_en = NG'(1) << a;
`ifdef REGWR_ZERO_REG_EN
            if (a == '0) e_en = '0;
`endif
            m_d    = req_data[w*BW +: BW];
            m_last = w;
            m_ptr  = (w + 1) % NR;
        end
        exp_q.push_back({e_en, m_d, GW'(m_last)});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd1, 32'd0);
        end else begin
            e   = exp_q.pop_front();
            got = {reg_en, reg_d, last_grant};
            check("reg_en", 32'(got[EW-1 -: NG]), 32'(e[EW-1 -: NG]));
            check("reg_d", 32'(got[GW +: BW]), 32'(e[GW +: BW]));
            check("last_grant", 32'(got[GW-1:0]), 32'(e[GW-1:0]));
        end
        check("ptr", 32'(dut.ptr), 32'(m_ptr));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        hold  = 1'b0;
        clear_req();
        model_reset();
        #2;
        check("rst_reg_en", 32'(reg_en), 32'h0);
        check("rst_reg_d", 32'(reg_d), 32'h0);
        check("rst_last_grant", 32'(last_grant), 32'h0);
        req_valid = 4'b1111;
        #1;
        check("rst_ready_ptr0", 32'(req_ready), 32'b0001);
        hold = 1'b1;
        #1;
        check("rst_ready_hold", 32'(req_ready), 32'h0);
        hold = 1'b0;
        clear_req();
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // single request: requester 2 -> addr 5 = 0xA5
        set_req(2, 3'd5, 8'hA5);
        #1;
        check("single_ready", 32'(req_ready), 32'b0100);
        step();
        check("single_en", 32'(reg_en), 32'h20);
        clear_req();
        step();
        check("single_idle_en", 32'(reg_en), 32'h0);
        check("single_d_hold", 32'(reg_d), 32'hA5);

        // rotation: all four valid, addr = data = i; ptr is now 3
        for (int i = 0; i < NR; i++) set_req(i, AW'(i), BW'(i));
        step();
        for (int c = 0; c < 8; c++) begin
            step();
            check("rot_order", 32'(last_grant), 32'(c % NR));
        end
        clear_req();
        step();

        // stall: hold for three cycles with requester 1 valid
        hold = 1'b1;
        set_req(1, 3'd6, 8'h5C);
        for (int c = 0; c < 3; c++) begin
            step();
            check("stall_en", 32'(reg_en), 32'h0);
        end
        hold = 1'b0;
        step();
        check("stall_release_grant", 32'(last_grant), 32'd1);
        check("stall_release_en", 32'(reg_en), 32'h40);
        clear_req();

        // same-address conflict: r0 then r1 to addr 3
        set_req(0, 3'd3, 8'h11);
        step();
        check("conf_d1", 32'(reg_d), 32'h11);
        clear_req();
        set_req(1, 3'd3, 8'h22);
        step();
        check("conf_d2", 32'(reg_d), 32'h22);
        clear_req();
        step();
        check("conf_bank", 32'(bank[3]), 32'h22);

        // zero register: requester 3 writes addr 0
        set_req(3, 3'd0, 8'hFF);
        step();
        check("zero_grant", 32'(last_grant), 32'd3);
`ifdef REGWR_ZERO_REG_EN
        check("zero_en", 32'(reg_en), 32'h00);
`else
        check("zero_en", 32'(reg_en), 32'h01);
`endif
        clear_req();
        step();

        // reset mid-write: issue a write producing reg_en = 0x04, then assert rst
        set_req(2, 3'd2, 8'h77);
        step();
        check("mid_en_before", 32'(reg_en), 32'h04);
        clear_req();
        #2;
        rst = 1'b1;
        #1;
        check("mid_en_cleared", 32'(reg_en), 32'h0);
        check("mid_last_grant", 32'(last_grant), 32'h0);
        check("mid_ptr", 32'(dut.ptr), 32'h0);
        model_reset();
        for (int i = 0; i < NR; i++) set_req(i, AW'(i + 4), BW'(8'h30 + i));
        #1;
        rst = 1'b0;
        step();
        check("post_rst_first", 32'(last_grant), 32'd0);
        clear_req();

        // random traffic
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < NR; i++) begin
                req_valid[i]         = 1'($urandom_range(0, 1));
                req_addr[i*AW +: AW] = AW'($urandom_range(0, NG - 1));
                req_data[i*BW +: BW] = BW'($urandom_range(0, 255));
            end
            hold = ($urandom_range(0, 5) == 0);
            step();
        end
        hold = 1'b0;
        clear_req();
        step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
